// File: rtl/rx_frame_controller.sv
// rx_frame_controller: FWFT byte FIFO with parity-error tracking, overrun flag and idle-timeout frame delimiter.
module rx_frame_controller #(
    parameter int FIFO_DEPTH  = 4,
    parameter int IDLE_CYCLES = 160
) (
    input  logic                          clk,
    input  logic                          reset_n,
    input  logic                          enable,
    input  logic [7:0]                    rx_byte,
    input  logic                          rx_valid,
    input  logic                          rx_error,
    output logic [7:0]                    m_data,
    output logic                          m_error,
    output logic                          m_valid,
    input  logic                          m_ready,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_level,
    output logic                          overrun,
    output logic [7:0]                    err_count,
    input  logic                          clr_status,
    output logic                          frame_end
);
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam int IW = $clog2(IDLE_CYCLES);
    localparam logic [IW-1:0] IDLE_LAST = IW'(IDLE_CYCLES - 2);

    typedef enum logic [1:0] {DISABLED, WAIT_BYTE, IN_FRAME} state_t;

    logic [8:0]    mem_q [FIFO_DEPTH];
    logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
    logic [AW:0]   level_q, level_d;
    logic          overrun_q, overrun_d, frame_end_q, frame_end_d;
    logic [7:0]    err_q, err_d;
    logic [IW-1:0] idle_q, idle_d;
    state_t        state_q, state_d;
    logic          push, pop, full, wr_en;

    assign m_valid    = level_q != '0;
    assign full       = level_q == (AW+1)'(FIFO_DEPTH);
    assign push       = rx_valid & enable;
    assign pop        = m_valid & m_ready;
    // A push at full still lands when the head leaves in the same cycle.
    assign wr_en      = push & (~full | pop);
    assign m_data     = m_valid ? mem_q[rd_ptr_q][7:0] : 8'd0;
    assign m_error    = m_valid & mem_q[rd_ptr_q][8];
    assign fifo_level = level_q;
    assign overrun    = overrun_q;
    assign err_count  = err_q;
    assign frame_end  = frame_end_q;

    always_comb begin
        wr_ptr_d  = wr_ptr_q + AW'(wr_en);
        rd_ptr_d  = rd_ptr_q + AW'(pop);
        level_d   = (wr_en && !pop) ? level_q + 1'b1 : (pop && !wr_en) ? level_q - 1'b1 : level_q;
        overrun_d = (clr_status ? 1'b0 : overrun_q) | (push & full & ~pop);
        err_d     = clr_status ? 8'd0 : err_q;
        err_d     = (push && rx_error && err_d != 8'hFF) ? err_d + 8'd1 : err_d;
    end

    always_comb begin
        state_d     = state_q;
        idle_d      = idle_q;
        frame_end_d = 1'b0;
        if (!enable) begin
            state_d = DISABLED;
            idle_d  = '0;
        end else begin
            case (state_q)
                DISABLED:  state_d = WAIT_BYTE;
                WAIT_BYTE: if (push) begin
                    state_d = IN_FRAME;
                    idle_d  = '0;
                end
                IN_FRAME: if (push) begin
                    idle_d = '0;
                end else if (idle_q == IDLE_LAST) begin
                    frame_end_d = 1'b1;
                    state_d     = WAIT_BYTE;
                    idle_d      = '0;
                end else begin
                    idle_d = idle_q + 1'b1;
                end
                default:   state_d = DISABLED;
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (wr_en) mem_q[wr_ptr_q] <= {rx_error, rx_byte};
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            wr_ptr_q    <= '0;
            rd_ptr_q    <= '0;
            level_q     <= '0;
            overrun_q   <= 1'b0;
            err_q       <= 8'd0;
            frame_end_q <= 1'b0;
            idle_q      <= '0;
            state_q     <= DISABLED;
        end else begin
            wr_ptr_q    <= wr_ptr_d;
            rd_ptr_q    <= rd_ptr_d;
            level_q     <= level_d;
            overrun_q   <= overrun_d;
            err_q       <= err_d;
            frame_end_q <= frame_end_d;
            idle_q      <= idle_d;
            state_q     <= state_d;
        end
    end
endmodule

// File: tb/tb_rx_frame_controller.sv
// tb_rx_frame_controller: directed scenario tasks for rx_frame_controller.
module tb_rx_frame_controller;
    localparam int IC = 10;
    logic       clk = 1'b0, reset_n = 1'b0, enable = 1'b0;
    logic [7:0] rx_byte = 8'd0;
    logic       rx_valid = 1'b0, rx_error = 1'b0, m_ready = 1'b0, clr_status = 1'b0;
    logic [7:0] m_data, err_count;
    logic       m_error, m_valid, overrun, frame_end;
    logic [2:0] fifo_level;
    int         n_pass = 0, n_total = 0;

    rx_frame_controller #(.FIFO_DEPTH(4), .IDLE_CYCLES(IC)) dut (
        .clk(clk), .reset_n(reset_n), .enable(enable), .rx_byte(rx_byte),
        .rx_valid(rx_valid), .rx_error(rx_error), .m_data(m_data), .m_error(m_error),
        .m_valid(m_valid), .m_ready(m_ready), .fifo_level(fifo_level), .overrun(overrun),
        .err_count(err_count), .clr_status(clr_status), .frame_end(frame_end)
    );

    always #5 clk = ~clk;

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic test_reset();
        tick();
        n_total++;
        if ({m_valid, m_error, m_data, fifo_level, overrun, err_count, frame_end} !== 21'd0)
            $display("FAIL reset_state: got v=%0b e=%0b d=%0h l=%0d o=%0b c=%0d f=%0b required all 0",
                     m_valid, m_error, m_data, fifo_level, overrun, err_count, frame_end);
        else n_pass++;
        reset_n = 1'b1;
        enable  = 1'b1;
        tick();
    endtask

    task automatic test_basic();
        m_ready = 1'b0;
        rx_valid = 1'b1; rx_byte = 8'hA5; tick();
        rx_byte = 8'h3C; tick();
        rx_valid = 1'b0;
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'hA5 || fifo_level !== 3'd2)
            $display("FAIL basic_hold: got v=%0b d=%0h l=%0d required v=1 d=a5 l=2", m_valid, m_data, fifo_level);
        else n_pass++;
        m_ready = 1'b1; tick();
        n_total++;
        if (m_data !== 8'h3C) $display("FAIL basic_second: got %0h required 3c", m_data);
        else n_pass++;
        tick();
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL basic_empty: got m_valid=%0b required 0", m_valid);
        else n_pass++;
    endtask

    task automatic test_overrun();
        m_ready = 1'b0;
        for (int i = 1; i <= 5; i++) begin
            rx_valid = 1'b1; rx_byte = 8'(i); tick();
        end
        rx_valid = 1'b0;
        n_total++;
        if (fifo_level !== 3'd4 || overrun !== 1'b1)
            $display("FAIL overrun_set: got l=%0d o=%0b required l=4 o=1", fifo_level, overrun);
        else n_pass++;
        m_ready = 1'b1;
        for (int i = 1; i <= 4; i++) begin
            n_total++;
            if (m_data !== 8'(i)) $display("FAIL overrun_read: got %0h required %0h", m_data, i);
            else n_pass++;
            tick();
        end
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL overrun_drain: got m_valid=%0b required 0", m_valid);
        else n_pass++;
        m_ready = 1'b0;
        clr_status = 1'b1; tick(); clr_status = 1'b0;
        n_total++;
        if (overrun !== 1'b0) $display("FAIL overrun_clear: got %0b required 0", overrun);
        else n_pass++;
    endtask

    task automatic test_full_pop();
        m_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            rx_valid = 1'b1; rx_byte = 8'h10 + 8'(i); tick();
        end
        rx_byte = 8'h14; m_ready = 1'b1; tick();
        rx_valid = 1'b0;
        n_total++;
        if (overrun !== 1'b0 || fifo_level !== 3'd4)
            $display("FAIL full_pop: got o=%0b l=%0d required o=0 l=4", overrun, fifo_level);
        else n_pass++;
        for (int i = 1; i <= 4; i++) begin
            n_total++;
            if (m_data !== 8'h10 + 8'(i)) $display("FAIL full_pop_order: got %0h required %0h", m_data, 8'h10 + i);
            else n_pass++;
            tick();
        end
        n_total++;
        if (m_valid !== 1'b0) $display("FAIL full_pop_drain: got m_valid=%0b required 0", m_valid);
        else n_pass++;
    endtask

    task automatic test_errors();
        int bad = 0;
        m_ready = 1'b1;
        for (int i = 0; i < 300; i++) begin
            rx_valid = 1'b1; rx_error = 1'b1; rx_byte = 8'(i); tick();
            if (m_error !== 1'b1 || m_valid !== 1'b1) bad++;
        end
        rx_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL err_flag: got %0d heads without m_error required 0", bad);
        else n_pass++;
        n_total++;
        if (err_count !== 8'd255) $display("FAIL err_saturate: got %0d required 255", err_count);
        else n_pass++;
        clr_status = 1'b1; rx_valid = 1'b1; tick();
        clr_status = 1'b0; rx_valid = 1'b0; rx_error = 1'b0;
        n_total++;
        if (err_count !== 8'd1) $display("FAIL err_clear_push: got %0d required 1", err_count);
        else n_pass++;
        tick();
        enable = 1'b0; m_ready = 1'b0; rx_valid = 1'b1; rx_error = 1'b1; tick();
        rx_valid = 1'b0; rx_error = 1'b0;
        n_total++;
        if (fifo_level !== 3'd0 || err_count !== 8'd1 || overrun !== 1'b0)
            $display("FAIL disabled_ignore: got l=%0d c=%0d o=%0b required l=0 c=1 o=0", fifo_level, err_count, overrun);
        else n_pass++;
        enable = 1'b1; tick();
    endtask

    task automatic test_frame();
        int bad = 0;
        m_ready = 1'b1;
        enable = 1'b0; tick(); enable = 1'b1; tick();
        rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        for (int k = 1; k < IC; k++) begin
            tick();
            n_total++;
            if (frame_end !== (k == IC - 1)) $display("FAIL frame_timeout: k=%0d got %0b required %0b", k, frame_end, k == IC - 1);
            else n_pass++;
        end
        tick();
        n_total++;
        if (frame_end !== 1'b0) $display("FAIL frame_one_cycle: got %0b required 0", frame_end);
        else n_pass++;
        rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        for (int k = 1; k <= IC - 2; k++) begin
            rx_valid = (k == IC - 2); tick();
            if (frame_end !== 1'b0) bad++;
        end
        for (int k = 1; k <= IC - 1; k++) begin
            rx_valid = (k == IC - 1); tick();
            if (frame_end !== 1'b0) bad++;
        end
        rx_valid = 1'b0;
        n_total++;
        if (bad != 0) $display("FAIL frame_restart: got %0d stray pulses required 0", bad);
        else n_pass++;
        for (int k = 1; k < IC; k++) tick();
        n_total++;
        if (frame_end !== 1'b1) $display("FAIL frame_after_restart: got %0b required 1", frame_end);
        else n_pass++;
        bad = 0;
        rx_valid = 1'b1; tick(); rx_valid = 1'b0;
        tick(); tick();
        enable = 1'b0; tick(); enable = 1'b1;
        for (int k = 0; k < IC + 2; k++) begin
            if (frame_end !== 1'b0) bad++;
            tick();
        end
        n_total++;
        if (bad != 0) $display("FAIL frame_disable: got %0d pulses required 0", bad);
        else n_pass++;
    endtask

    task automatic test_reset_mid();
        m_ready = 1'b0;
        for (int i = 0; i < 3; i++) begin
            rx_valid = 1'b1; rx_byte = 8'h50 + 8'(i); tick();
        end
        rx_valid = 1'b0;
        n_total++;
        if (fifo_level !== 3'd3) $display("FAIL mid_fill: got %0d required 3", fifo_level);
        else n_pass++;
        #2 reset_n = 1'b0;
        #1;
        n_total++;
        if ({m_valid, m_error, m_data, fifo_level, overrun, err_count, frame_end} !== 21'd0)
            $display("FAIL mid_reset: got v=%0b e=%0b d=%0h l=%0d o=%0b c=%0d f=%0b required all 0",
                     m_valid, m_error, m_data, fifo_level, overrun, err_count, frame_end);
        else n_pass++;
        tick();
        reset_n = 1'b1;
        rx_valid = 1'b1; rx_byte = 8'h77; tick(); rx_valid = 1'b0;
        n_total++;
        if (m_valid !== 1'b1 || m_data !== 8'h77 || fifo_level !== 3'd1)
            $display("FAIL post_reset_push: got v=%0b d=%0h l=%0d required v=1 d=77 l=1", m_valid, m_data, fifo_level);
        else n_pass++;
    endtask

    initial begin
        test_reset();
        test_basic();
        test_overrun();
        test_full_pop();
        test_errors();
        test_frame();
        test_reset_mid();
        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end
endmodule

// File: doc/rx_frame_controller.md
RX_FRAME_CONTROLLER -- requirements
Module: rx_frame_controller

Interface
REQ-001 SHALL have parameter FIFO_DEPTH, default 4, number of buffered bytes; a power of two, at least 2.
REQ-002 SHALL have parameter IDLE_CYCLES, default 160, number of idle clk cycles after a byte that ends a frame; at least 2.
REQ-003 SHALL have port clk, input, 1, single clock; all logic rising-edge.
REQ-004 SHALL have port reset_n, input, 1, asynchronous active-low reset.
REQ-005 SHALL have port enable, input, 1, accept new bytes when high.
REQ-006 SHALL have port rx_byte, input, 8, received byte from the UART receive path.
REQ-007 SHALL have port rx_valid, input, 1, one-cycle strobe meaning rx_byte is complete.
REQ-008 SHALL have port rx_error, input, 1, parity error flag, sampled only when rx_valid=1.
REQ-009 SHALL have port m_data, output, 8, FIFO head byte.
REQ-010 SHALL have port m_error, output, 1, parity flag stored with the head byte.
REQ-011 SHALL have port m_valid, output, 1, FIFO holds at least one entry.
REQ-012 SHALL have port m_ready, input, 1, consumer accepts the head byte.
REQ-013 SHALL have port fifo_level, output, clog2(FIFO_DEPTH)+1, current entry count.
REQ-014 SHALL have port overrun, output, 1, sticky flag for a dropped byte.
REQ-015 SHALL have port err_count, output, 8, saturating count of bytes with parity errors.
REQ-016 SHALL have port clr_status, input, 1, one-cycle clear of overrun and err_count.
REQ-017 SHALL have port frame_end, output, 1, one-cycle pulse when a frame ends on idle timeout.

Function
REQ-018 SHALL form a push when rx_valid=1 and enable=1; SHALL ignore rx_valid while enable=0, with no FIFO write, no counter change and no flag change.
REQ-019 SHALL form a pop when m_valid=1 and m_ready=1; m_data and m_error SHALL hold stable while m_valid=1 and m_ready=0.
REQ-020 SHALL be first-word-fall-through: a byte pushed at edge N SHALL appear on m_data with m_valid=1 after edge N when the FIFO was empty.
REQ-021 SHALL store each byte together with its rx_error bit as a 9-bit entry; read and write pointers SHALL wrap modulo FIFO_DEPTH.
REQ-022 SHALL accept both operations when push and pop occur in the same cycle, at any level including full; fifo_level SHALL then be unchanged.
REQ-023 SHALL drop the byte and set overrun when a push occurs with the FIFO full and no same-cycle pop; FIFO contents and fifo_level SHALL be unchanged.
REQ-024 SHALL ignore a pop while the FIFO is empty (m_valid=0).
REQ-025 SHALL increment err_count on every push with rx_error=1, including dropped bytes, saturating at 255.
REQ-026 SHALL clear overrun and err_count on clr_status=1, then apply any same-cycle event, so the result is a count of 1 or overrun=1.
REQ-027 SHALL implement a frame FSM with three states: DISABLED, WAIT_BYTE and IN_FRAME.
REQ-028 SHALL move DISABLED->WAIT_BYTE when enable=1, and from any state to DISABLED when enable=0; the DISABLED transition SHALL clear the idle counter without pulsing frame_end.
REQ-029 SHALL move WAIT_BYTE->IN_FRAME on a push and load the idle counter with 0.
REQ-030 SHALL, in IN_FRAME, reset the idle counter to 0 on a push and otherwise increment it.
REQ-031 SHALL, when the idle counter reaches IDLE_CYCLES-1 without a push, pulse frame_end for one cycle and move to WAIT_BYTE.
REQ-032 SHALL give a push priority over timeout in the same cycle, with no frame_end.
REQ-033 SHALL treat a dropped byte (REQ-023) as a push for the FSM.
REQ-034 SHALL drive m_valid, fifo_level, overrun, err_count and frame_end from registers or from pointer state only, with no combinational path from rx_* inputs.

Reset
REQ-035 SHALL, on reset_n=0, immediately force pointers=0, fifo_level=0, m_valid=0, m_error=0, m_data=0, overrun=0, err_count=0, frame_end=0, idle counter=0 and FSM=DISABLED.
REQ-036 SHALL discard buffered bytes on a reset asserted mid-operation; the first enabled cycle after release SHALL enter WAIT_BYTE.

Verification
REQ-037 Push 0xA5 then 0x3C with rx_error=0 and m_ready=0 -> m_valid=1, m_data=0xA5, fifo_level=2; raise m_ready -> 0xA5 then 0x3C, then m_valid=0.
REQ-038 Push 5 bytes 0x01..0x05 with m_ready=0 (depth 4) -> fifo_level=4, overrun=1, reads return 0x01..0x04; clr_status -> overrun=0.
REQ-039 Push at full with m_ready=1 in the same cycle -> no overrun, fifo_level stays 4, new byte is read last.
REQ-040 Push 300 bytes with rx_error=1 while draining -> err_count=255, m_error=1 on each; clr_status together with an error push -> err_count=1.
REQ-041 Push one byte, then idle IDLE_CYCLES cycles -> a single frame_end pulse IDLE_CYCLES-1 cycles after the push edge; a byte at IDLE_CYCLES-2 restarts the count with no pulse.
REQ-042 Assert reset_n=0 with 3 bytes buffered, or toggle enable=0 in IN_FRAME -> all outputs 0 per REQ-035, or FSM=DISABLED with no frame_end.
